// File: rtl/sysid_checker_pkg.sv
// -----------------------------------------------------------------------------
// sysid_checker_pkg
//   Shared types and constants for the system-ID checker.
//   - sysid_state_t : checker sequencer states
//   - SYSID_ADDR_*  : word addresses inside the sysid responder
//   - SYSID_DEFAULT_* : expected values baked into the current bitstream
// -----------------------------------------------------------------------------
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_ID  = 3'd1,
        WAIT_ID = 3'd2,
        REQ_TS  = 3'd3,
        WAIT_TS = 3'd4,
        DONE    = 3'd5
    } sysid_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID = 32'd0;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1427154916;

endpackage

// File: rtl/niosii_system_sysid_checker.sv
// -----------------------------------------------------------------------------
// niosii_system_sysid_checker
//   Avalon-MM master that reads the sysid responder (word 0 = ID, word 1 =
//   build timestamp) after a start pulse and compares both words against
//   compile-time expected values.
//
//   Ports
//     clock, reset_n          : block clock, async active-low reset
//     start                   : one-cycle pulse, honoured only in IDLE/DONE
//     avm_address, avm_read   : registered read request to the fabric
//     avm_waitrequest         : fabric stall, request held while high
//     avm_readdata/valid      : read response
//     busy                    : sequence in progress
//     done                    : sequence finished, results valid
//     pass                    : id_match & ts_match & ~timeout (gated by done)
//     id_match, ts_match      : captured word equals expected value
//     timeout                 : a transaction ran past TIMEOUT_CYCLES
//     id_value, ts_value      : captured words
//
//   TIMEOUT_CYCLES must be >= 2 (a zero-wait read needs one request cycle
//   plus one data cycle).
// -----------------------------------------------------------------------------
module niosii_system_sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TS,
    parameter int          TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    sysid_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        in_txn;
    logic        last_cycle;
    logic        start_acc;
    logic        cap_id, cap_ts;
    logic        tmo_hit;
    logic        enter_req;

    logic        read_q, addr_q;
    logic        done_q, timeout_q;
    logic        id_cap_q, ts_cap_q;
    logic        id_match_q, ts_match_q;
    logic [31:0] id_value_q, ts_value_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cap_id    = 1'b0;
        cap_ts    = 1'b0;
        tmo_hit   = 1'b0;

        in_txn     = (state_q == REQ_ID) || (state_q == WAIT_ID) ||
                     (state_q == REQ_TS) || (state_q == WAIT_TS);
        // Counter starts at 0 in the first request cycle, so the cycle with
        // count TIMEOUT_CYCLES-1 is the last one a transaction may use.
        last_cycle = in_txn && (cnt_q == TMO_LAST);
        start_acc  = start && ((state_q == IDLE) || (state_q == DONE));

        unique case (state_q)
            IDLE, DONE: begin
                if (start) state_d = REQ_ID;
            end
            // Readdatavalid is not looked at in REQ states: data is only
            // legal after the request has been accepted.
            REQ_ID: begin
                if (last_cycle) begin
                    tmo_hit = 1'b1;
                    state_d = DONE;
                end else if (!avm_waitrequest) begin
                    state_d = WAIT_ID;
                end
            end
            WAIT_ID: begin
                if (avm_readdatavalid) begin
                    cap_id  = 1'b1;
                    state_d = REQ_TS;
                end else if (last_cycle) begin
                    tmo_hit = 1'b1;
                    state_d = DONE;
                end
            end
            REQ_TS: begin
                if (last_cycle) begin
                    tmo_hit = 1'b1;
                    state_d = DONE;
                end else if (!avm_waitrequest) begin
                    state_d = WAIT_TS;
                end
            end
            WAIT_TS: begin
                if (avm_readdatavalid) begin
                    cap_ts  = 1'b1;
                    state_d = DONE;
                end else if (last_cycle) begin
                    tmo_hit = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        enter_req = ((state_d == REQ_ID) || (state_d == REQ_TS)) && (state_d != state_q);

        cnt_d = cnt_q;
        if (enter_req)   cnt_d = '0;
        else if (in_txn) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered Avalon request. Derived from the next state so read and
    // address change only on state transitions and therefore stay put for
    // as long as the fabric holds waitrequest.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_q <= 1'b0;
            addr_q <= SYSID_ADDR_ID;
        end else begin
            read_q <= (state_d == REQ_ID) || (state_d == REQ_TS);
            if (state_d == REQ_ID)      addr_q <= SYSID_ADDR_ID;
            else if (state_d == REQ_TS) addr_q <= SYSID_ADDR_TS;
        end
    end

    // ------------------------------------------------------------------
    // Captured words and result flags
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_value_q <= '0;
            ts_value_q <= '0;
            id_cap_q   <= 1'b0;
            ts_cap_q   <= 1'b0;
        end else if (start_acc) begin
            id_value_q <= '0;
            ts_value_q <= '0;
            id_cap_q   <= 1'b0;
            ts_cap_q   <= 1'b0;
        end else begin
            if (cap_id) begin
                id_value_q <= avm_readdata;
                id_cap_q   <= 1'b1;
            end
            if (cap_ts) begin
                ts_value_q <= avm_readdata;
                ts_cap_q   <= 1'b1;
            end
        end
    end

    // Compare one cycle after capture; a word never captured never matches,
    // even if the expected value happens to equal the cleared register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_match_q <= 1'b0;
            ts_match_q <= 1'b0;
        end else if (start_acc) begin
            id_match_q <= 1'b0;
            ts_match_q <= 1'b0;
        end else begin
            id_match_q <= id_cap_q && (id_value_q == EXPECTED_ID);
            ts_match_q <= ts_cap_q && (ts_value_q == EXPECTED_TIMESTAMP);
        end
    end

    // done lags entry to DONE by one cycle so the last match flag has
    // already settled when done rises.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else if (start_acc) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
            if (tmo_hit) timeout_q <= 1'b1;
        end
    end

    assign avm_read    = read_q;
    assign avm_address = addr_q;
    assign busy        = (state_q == REQ_ID) || (state_q == WAIT_ID) ||
                         (state_q == REQ_TS) || (state_q == WAIT_TS);
    assign done        = done_q;
    assign pass        = done_q & id_match_q & ts_match_q & ~timeout_q;
    assign id_match    = id_match_q;
    assign ts_match    = ts_match_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_niosii_system_sysid_checker
//   Directed bench: a small sysid responder model with programmable wait
//   states and muting, a table of sequences with hand-computed results, and
//   hand-written sequences for start-while-busy, stray data and mid-read reset.
// -----------------------------------------------------------------------------
module tb_niosii_system_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'd1427154916;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        busy, done, pass, id_match, ts_match, timeout;
    logic [31:0] id_value, ts_value;

    niosii_system_sysid_checker #(
        .EXPECTED_ID        (32'd0),
        .EXPECTED_TIMESTAMP (TS_GOOD),
        .TIMEOUT_CYCLES     (8)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .id_match          (id_match),
        .ts_match          (ts_match),
        .timeout           (timeout),
        .id_value          (id_value),
        .ts_value          (ts_value)
    );

    always #5 clock = ~clock;

    // ---------------- responder model ----------------
    int          ws      = 0;
    bit          mute_id = 1'b0;
    bit          mute_ts = 1'b0;
    logic [31:0] id_data = 32'd0;
    logic [31:0] ts_data = TS_GOOD;
    logic        stray_rdv  = 1'b0;
    logic [31:0] stray_data = 32'd0;

    int          stall;
    logic        rsp_rdv;
    logic [31:0] rsp_data;

    assign avm_waitrequest   = avm_read && (stall < ws);
    assign avm_readdatavalid = rsp_rdv | stray_rdv;
    assign avm_readdata      = stray_rdv ? stray_data : rsp_data;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall    <= 0;
            rsp_rdv  <= 1'b0;
            rsp_data <= '0;
        end else begin
            rsp_rdv <= 1'b0;
            if (avm_read && avm_waitrequest) begin
                stall <= stall + 1;
            end else if (avm_read) begin
                stall <= 0;
                if (!(avm_address ? mute_ts : mute_id)) begin
                    rsp_rdv  <= 1'b1;
                    rsp_data <= avm_address ? ts_data : id_data;
                end
            end
        end
    end

    // ---------------- monitors ----------------
    int   read_starts = 0;
    int   ts_starts   = 0;
    int   stab_viol   = 0;
    logic prev_rd, prev_ts, prev_req, prev_addr;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_rd   <= 1'b0;
            prev_ts   <= 1'b0;
            prev_req  <= 1'b0;
            prev_addr <= 1'b0;
        end else begin
            prev_rd   <= avm_read;
            prev_ts   <= avm_read && avm_address;
            prev_req  <= avm_read && avm_waitrequest;
            prev_addr <= avm_address;
            if (avm_read && !prev_rd)                 read_starts <= read_starts + 1;
            if (avm_read && avm_address && !prev_ts)  ts_starts   <= ts_starts + 1;
        end
    end

    // A stalled request must reappear unchanged in the following cycle.
    always @(negedge clock) begin
        if (reset_n && prev_req && (!avm_read || (avm_address != prev_addr)))
            stab_viol <= stab_viol + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    typedef struct {
        int          ws;
        bit          mute_id;
        bit          mute_ts;
        logic [31:0] id_data;
        logic [31:0] ts_data;
        int          lat;       // edges from start edge to done
        bit          pass;
        bit          idm;
        bit          tsm;
        bit          to;
        logic [31:0] idv;
        logic [31:0] tsv;
        int          ts_reads;
    } vec_t;

    task automatic run_row(input vec_t v, input int r);
        int lat;
        int ts0;
        ws      = v.ws;
        mute_id = v.mute_id;
        mute_ts = v.mute_ts;
        id_data = v.id_data;
        ts_data = v.ts_data;
        ts0     = ts_starts;
        pulse_start();
        check($sformatf("r%0d read_after_start", r), {31'd0, avm_read}, 32'd1);
        check($sformatf("r%0d addr_after_start", r), {31'd0, avm_address}, 32'd0);
        check($sformatf("r%0d done_cleared", r), {31'd0, done}, 32'd0);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        check($sformatf("r%0d done_latency", r), lat, v.lat);
        check($sformatf("r%0d pass", r), {31'd0, pass}, {31'd0, v.pass});
        check($sformatf("r%0d id_match", r), {31'd0, id_match}, {31'd0, v.idm});
        check($sformatf("r%0d ts_match", r), {31'd0, ts_match}, {31'd0, v.tsm});
        check($sformatf("r%0d timeout", r), {31'd0, timeout}, {31'd0, v.to});
        check($sformatf("r%0d id_value", r), id_value, v.idv);
        check($sformatf("r%0d ts_value", r), ts_value, v.tsv);
        check($sformatf("r%0d busy_idle", r), {30'd0, busy, avm_read}, 32'd0);
        check($sformatf("r%0d ts_reads", r), ts_starts - ts0, v.ts_reads);
    endtask

    vec_t vecs[8];

    initial begin
        int rs0;
        int found;

        //        ws mid mts id_data  ts_data        lat pass idm tsm to idv      tsv            tsr
        vecs[0] = '{0, 0, 0, 32'd0,   TS_GOOD,        5,  1,  1,  1,  0, 32'd0,   TS_GOOD,        1};
        vecs[1] = '{0, 0, 0, 32'd0,   32'd1427154917, 5,  0,  1,  0,  0, 32'd0,   32'd1427154917, 1};
        vecs[2] = '{0, 0, 0, 32'd5,   TS_GOOD,        5,  0,  0,  1,  0, 32'd5,   TS_GOOD,        1};
        vecs[3] = '{3, 0, 0, 32'd0,   TS_GOOD,        11, 1,  1,  1,  0, 32'd0,   TS_GOOD,        1};
        // 6 stalls + accept + data = exactly 8 cycles: still in budget
        vecs[4] = '{6, 0, 0, 32'd0,   TS_GOOD,        17, 1,  1,  1,  0, 32'd0,   TS_GOOD,        1};
        // 7 stalls: ID request times out on its 8th cycle
        vecs[5] = '{7, 0, 0, 32'd0,   TS_GOOD,        9,  0,  0,  0,  1, 32'd0,   32'd0,          0};
        // no data for word 0: ID value 0 equals expected but was never captured
        vecs[6] = '{0, 1, 0, 32'd0,   TS_GOOD,        9,  0,  0,  0,  1, 32'd0,   32'd0,          0};
        vecs[7] = '{0, 0, 1, 32'd0,   TS_GOOD,        11, 0,  1,  0,  1, 32'd0,   32'd0,          1};

        // reset state
        #12;
        check("reset_flags", {24'd0, avm_read, avm_address, busy, done, pass, id_match, ts_match, timeout}, 32'd0);
        check("reset_id_value", id_value, 32'd0);
        check("reset_ts_value", ts_value, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // stray readdatavalid in IDLE
        @(negedge clock);
        stray_data = 32'hCAFEF00D;
        stray_rdv  = 1'b1;
        @(posedge clock);
        #1;
        stray_rdv = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("idle_stray_id", id_value, 32'd0);
        check("idle_stray_ts", ts_value, 32'd0);
        check("idle_stray_state", {29'd0, busy, done, avm_read}, 32'd0);

        for (int r = 0; r < 8; r++) run_row(vecs[r], r);

        check("waitreq_stability_violations", stab_viol, 0);

        // start pulsed in WAIT_TS is ignored
        ws = 0; mute_id = 0; mute_ts = 0; id_data = 32'd0; ts_data = TS_GOOD;
        pulse_start();
        repeat (3) @(posedge clock);
        #1;
        check("wait_ts_busy", {31'd0, busy}, 32'd1);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        check("busy_start_done", {31'd0, done}, 32'd1);
        check("busy_start_pass", {31'd0, pass}, 32'd1);
        rs0 = read_starts;
        repeat (3) @(posedge clock);
        #1;
        check("busy_start_no_restart", read_starts - rs0, 0);

        // stray readdatavalid in DONE
        @(negedge clock);
        stray_rdv = 1'b1;
        @(posedge clock);
        #1;
        stray_rdv = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("done_stray_ts", ts_value, TS_GOOD);
        check("done_stray_id", id_value, 32'd0);
        check("done_stray_pass", {30'd0, done, pass}, 32'd3);

        // reset during REQ_TS
        ws = 3; id_data = 32'h1234;
        pulse_start();
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (avm_read && avm_address) begin
                found = 1;
                break;
            end
        end
        check("reach_req_ts", found, 1);
        check("req_ts_id_captured", id_value, 32'h1234);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_flags", {24'd0, avm_read, avm_address, busy, done, pass, id_match, ts_match, timeout}, 32'd0);
        check("async_reset_id", id_value, 32'd0);
        check("async_reset_ts", ts_value, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        rs0 = read_starts;
        repeat (10) @(posedge clock);
        #1;
        check("post_reset_no_read", read_starts - rs0, 0);
        check("post_reset_idle", {29'd0, busy, done, avm_read}, 32'd0);

        // recovery from IDLE after reset
        run_row(vecs[0], 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/niosii_system_sysid_checker.md
# niosII_system_sysid_checker

Avalon-MM master that reads the system-ID responder over the Qsys fabric and checks it against compile-time expected values. On `start` it reads word 0 (system ID) then word 1 (build timestamp), captures both, compares them to parameters, and reports pass, fail or timeout. It sits beside the Nios II on the same clock domain and gates software boot or flags a stale bitstream on a status LED or register.

## Interface
Parameters:
- `EXPECTED_ID`, 32'd0: value required at word 0.
- `EXPECTED_TIMESTAMP`, 32'd1427154916: value required at word 1.
- `TIMEOUT_CYCLES`, 255: maximum number of cycles per read transaction, counted from the first `avm_read` cycle to `avm_readdatavalid`. Must be ≥ 2.

Ports:
- `clock`  in  1  single clock for the block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that begins a check sequence.
- `avm_address`  out  1  word address: 0 selects ID, 1 selects timestamp.
- `avm_read`  out  1  read request.
- `avm_waitrequest`  in  1  fabric stall.
- `avm_readdata`  in  32  read data.
- `avm_readdatavalid`  in  1  read data qualifier.
- `busy`  out  1  high while a sequence is in progress.
- `done`  out  1  high from sequence completion until the next accepted `start`.
- `pass`  out  1  `id_match & ts_match & ~timeout`; valid only while `done` is high.
- `id_match`  out  1  captured ID equals `EXPECTED_ID`.
- `ts_match`  out  1  captured timestamp equals `EXPECTED_TIMESTAMP`.
- `timeout`  out  1  a transaction exceeded `TIMEOUT_CYCLES`.
- `id_value`  out  32  captured ID.
- `ts_value`  out  32  captured timestamp.

## Operation
- FSM states and transitions:
  - IDLE: on `start`, go to REQ_ID.
  - REQ_ID: drive `avm_read`=1, `avm_address`=0. When `avm_waitrequest`=0, go to WAIT_ID.
  - WAIT_ID: on `avm_readdatavalid`, capture `id_value` and go to REQ_TS.
  - REQ_TS: drive `avm_read`=1, `avm_address`=1. When `avm_waitrequest`=0, go to WAIT_TS.
  - WAIT_TS: on `avm_readdatavalid`, capture `ts_value` and go to DONE.
  - DONE: on `start`, go to REQ_ID.
- Address and read stability:
  - `avm_read` and `avm_address` are registered.
  - Both are held constant while `avm_waitrequest`=1.
  - `avm_read` is 0 in every other state.
- `avm_readdatavalid` handling:
  - Sampled only in WAIT_ID and WAIT_TS.
  - Ignored in all other states, including stray data from an abandoned transaction.
- Accepting `start`:
  - `start` is honoured only in IDLE and DONE and is ignored while `busy`.
  - Accepting `start` clears `done`, `pass`, `id_match`, `ts_match`, `timeout`, `id_value` and `ts_value`.
- Timeout counter:
  - Width is `$clog2(TIMEOUT_CYCLES+1)`.
  - Cleared on entry to REQ_ID and REQ_TS; increments every cycle in REQ or WAIT states.
  - When it reaches `TIMEOUT_CYCLES` without valid data: set `timeout`=1, drop `avm_read`, go to DONE.
  - If a timeout occurs in the ID phase, the timestamp read is not issued.
- Match flags are registered in the cycle after each capture; they are 0 if the corresponding word was never captured.
- `busy` is high in the REQ and WAIT states.

## Timing
- Reset value of every output is 0, including `avm_read`, `avm_address` and both value buses. The FSM resets to IDLE.
- `start` at edge N → `avm_read`=1 after edge N.
- Zero-wait fabric with readdatavalid one cycle after acceptance: `start` at edge N → `done`=1 after edge N+5, with `pass` valid in the same cycle.
- Simultaneous `avm_waitrequest`=0 and `avm_readdatavalid`=1 in a REQ state: the data is not captured, because valid data is only legal after acceptance.
- Reset asserted mid-transaction returns the block to IDLE immediately; no read is re-issued after reset deasserts until a new `start`.

## Structure
- Shared package `sysid_checker_pkg` holds:
  - the state enum (IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, DONE);
  - `SYSID_ADDR_ID`=1'b0 and `SYSID_ADDR_TS`=1'b1;
  - the default expected-value constants.
- Single module, no sub-modules; the timeout counter is inline.

## Test plan
- Responder returns 0 / 1427154916 with zero wait states → `done` after 5 cycles, `pass`=1, `id_match`=1, `ts_match`=1.
- Responder returns timestamp 1427154917 → `pass`=0, `ts_match`=0, `id_match`=1, `ts_value`=1427154917.
- `avm_waitrequest` held high for 3 cycles on each read → `avm_read` and `avm_address` stay stable throughout, then `pass`=1 two reads later.
- Responder never asserts `avm_readdatavalid` for word 0, with `TIMEOUT_CYCLES`=8 → `timeout`=1, `pass`=0, only one read issued, `avm_read` drops.
- `start` pulsed during WAIT_TS, then a stray `avm_readdatavalid` in IDLE → no restart and no capture.
- `reset_n` asserted during REQ_TS → all outputs are 0 asynchronously; after release, no read occurs until `start`.
